data_memory_responder: RTL and testbench



---
 rtl/data_memory_responder.sv | 105 ++++++++++
 tb/tb_data_memory_responder.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_responder.sv
// Slow data-memory stand-in for the core's data port: one request at a time,
// serviced from an internal 64-bit word array after LATENCY busy cycles.
module data_memory_responder #(
  parameter int DEPTH_LOG2 = 8,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_cen_D,
  input  logic        mem_wen_D,
  input  logic [29:0] mem_addr_D,
  input  logic [63:0] mem_wdata_D,
  output logic [63:0] mem_rdata_D,
  output logic        mem_stall_D
);

  localparam int        Depth  = 1 << DEPTH_LOG2;
  localparam logic [3:0] LatCnt = 4'(LATENCY);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0] idx_q, idx_d;
  logic                  wen_q, wen_d;
  logic [63:0]           wdata_q, wdata_d;
  logic [63:0]           rdata_q;
  logic                  commit;
  logic [63:0]           mem_q [Depth];

  // Upper word-address bits are deliberately dropped so addresses alias.
  logic addr_unused;
  assign addr_unused = ^mem_addr_D[29:DEPTH_LOG2];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    wen_d       = wen_q;
    wdata_d     = wdata_q;
    mem_stall_D = 1'b0;
    commit      = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_cen_D) begin
          mem_stall_D = 1'b1;
          idx_d       = mem_addr_D[DEPTH_LOG2-1:0];
          wen_d       = mem_wen_D;
          wdata_d     = mem_wdata_D;
          cnt_d       = LatCnt;
          state_d     = BUSY;
        end
      end
      BUSY: begin
        mem_stall_D = 1'b1;
        cnt_d       = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          commit  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Captured request fields are only loaded from IDLE, so later input churn is ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      wen_q   <= 1'b0;
      wdata_q <= 64'd0;
      rdata_q <= 64'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
      if (commit && !wen_q) begin
        rdata_q <= mem_q[idx_q];
      end
    end
  end

  // The array has no reset; an aborted access never reaches the commit edge.
  always_ff @(posedge clk) begin
    if (commit && wen_q) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

  assign mem_rdata_D = rdata_q;

endmodule

// File: tb/tb_data_memory_responder.sv
// Scoreboard bench: instance 0 runs LATENCY=2, instance 1 runs LATENCY=1.
module tb_data_memory_responder;

  typedef struct {
    int          sel;
    logic [63:0] data;
    int          gap;
  } expT;

  logic        clk;
  logic        rst_n;
  logic        cen   [2];
  logic        wen   [2];
  logic [29:0] addr  [2];
  logic [63:0] wdata [2];
  logic [63:0] rdata [2];
  logic        stall [2];

  expT         expQ [$];
  logic [63:0] memModel [2][256];
  logic [63:0] lastRead [2];
  int          checks = 0;
  int          fails  = 0;
  int          busyCnt   [2];
  int          sinceDone [2];
  int          latency   [2];

  data_memory_responder #(.DEPTH_LOG2(8), .LATENCY(2)) dutLat2 (
    .clk(clk), .rst_n(rst_n), .mem_cen_D(cen[0]), .mem_wen_D(wen[0]),
    .mem_addr_D(addr[0]), .mem_wdata_D(wdata[0]),
    .mem_rdata_D(rdata[0]), .mem_stall_D(stall[0])
  );

  data_memory_responder #(.DEPTH_LOG2(8), .LATENCY(1)) dutLat1 (
    .clk(clk), .rst_n(rst_n), .mem_cen_D(cen[1]), .mem_wen_D(wen[1]),
    .mem_addr_D(addr[1]), .mem_wdata_D(wdata[1]),
    .mem_rdata_D(rdata[1]), .mem_stall_D(stall[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Monitor: a completion is the first non-stalled cycle after stalled ones.
  always @(negedge clk) begin
    expT e;
    for (int s = 0; s < 2; s++) begin
      sinceDone[s]++;
      if (!rst_n) begin
        busyCnt[s] = 0;
      end else if (stall[s]) begin
        busyCnt[s]++;
      end else if (busyCnt[s] > 0) begin
        if (expQ.size() == 0) begin
          checks++;
          fails++;
          $display("[TB] FAIL unexpected completion on dut %0d: got rdata %h, required no completion", s, rdata[s]);
        end else begin
          e = expQ.pop_front();
          checkOutput($sformatf("dut%0d sel", s), 64'(s), 64'(e.sel));
          checkOutput($sformatf("dut%0d rdata", s), rdata[s], e.data);
          checkOutput($sformatf("dut%0d stall cycles", s), 64'(busyCnt[s]), 64'(latency[s] + 1));
          if (e.gap > 0) begin
            checkOutput($sformatf("dut%0d done spacing", s), 64'(sinceDone[s]), 64'(e.gap));
          end
        end
        busyCnt[s]   = 0;
        sinceDone[s] = 0;
      end
    end
  end

  // Entered and left at posedge+1; a following request may start at once.
  task automatic applyStimulus(input int sel, input bit w, input logic [29:0] a,
                               input logic [63:0] d, input bit churn, input int gap);
    expT e;
    int  n;
    e.sel = sel;
    e.gap = gap;
    if (w) begin
      e.data = lastRead[sel];
      memModel[sel][a[7:0]] = d;
    end else begin
      e.data = memModel[sel][a[7:0]];
      lastRead[sel] = e.data;
    end
    expQ.push_back(e);
    cen[sel]   = 1'b1;
    wen[sel]   = w;
    addr[sel]  = a;
    wdata[sel] = d;
    @(posedge clk);
    #1;
    if (churn) begin
      addr[sel]  = a + 30'd1;
      wen[sel]   = 1'b1;
      wdata[sel] = 64'hBAD0_BAD0_BAD0_BAD0;
    end
    n = 0;
    forever begin
      @(negedge clk);
      if (!stall[sel]) break;
      n++;
      if (n > 40) begin
        checks++;
        fails++;
        $display("[TB] FAIL dut%0d completion timeout: got stall %b, required 0", sel, stall[sel]);
        break;
      end
    end
    @(posedge clk);
    #1;
    cen[sel] = 1'b0;
    wen[sel] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no end of test, required end of test");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    latency[0] = 2;
    latency[1] = 1;
    for (int s = 0; s < 2; s++) begin
      cen[s] = 1'b0; wen[s] = 1'b0; addr[s] = '0; wdata[s] = '0;
      busyCnt[s] = 0; sinceDone[s] = 0; lastRead[s] = 64'd0;
    end
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      checkOutput($sformatf("dut%0d reset rdata", s), rdata[s], 64'd0);
      checkOutput($sformatf("dut%0d reset stall", s), 64'(stall[s]), 64'd0);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] write then read, LATENCY=2");
    applyStimulus(0, 1'b1, 30'd5, 64'hDEAD_BEEF_0123_4567, 1'b0, 0);
    applyStimulus(0, 1'b0, 30'd5, 64'd0, 1'b0, 0);

    $display("[TB] idle hold");
    repeat (10) begin
      @(negedge clk);
      checkOutput("idle stall", 64'(stall[0]), 64'd0);
      checkOutput("idle rdata", rdata[0], 64'hDEAD_BEEF_0123_4567);
    end
    @(posedge clk);
    #1;

    $display("[TB] aliasing");
    applyStimulus(0, 1'b1, 30'd0, 64'h1, 1'b0, 0);
    applyStimulus(0, 1'b0, 30'd256, 64'd0, 1'b0, 0);

    $display("[TB] input churn");
    applyStimulus(0, 1'b1, 30'd3, 64'hAA, 1'b0, 0);
    applyStimulus(0, 1'b1, 30'd4, 64'h55, 1'b0, 0);
    applyStimulus(0, 1'b0, 30'd3, 64'd0, 1'b1, 0);
    applyStimulus(0, 1'b0, 30'd4, 64'd0, 1'b0, 0);

    $display("[TB] reset mid-access");
    applyStimulus(0, 1'b1, 30'd7, 64'h77, 1'b0, 0);
    cen[0] = 1'b1; wen[0] = 1'b1; addr[0] = 30'd7; wdata[0] = 64'h99;
    @(posedge clk);
    #3;
    rst_n  = 1'b0;
    cen[0] = 1'b0;
    wen[0] = 1'b0;
    #1;
    checkOutput("abort rdata", rdata[0], 64'd0);
    checkOutput("abort stall", 64'(stall[0]), 64'd0);
    lastRead[0] = 64'd0;
    lastRead[1] = 64'd0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(0, 1'b0, 30'd7, 64'd0, 1'b0, 0);

    $display("[TB] LATENCY=1 back-to-back");
    applyStimulus(1, 1'b1, 30'd1, 64'h1111, 1'b0, 0);
    applyStimulus(1, 1'b1, 30'd2, 64'h2222, 1'b0, 3);
    applyStimulus(1, 1'b0, 30'd1, 64'd0, 1'b0, 0);
    applyStimulus(1, 1'b0, 30'd2, 64'd0, 1'b0, 3);
    applyStimulus(1, 1'b0, 30'd1, 64'd0, 1'b0, 3);

    repeat (3) @(negedge clk);
    checkOutput("scoreboard drained", 64'(expQ.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
